serial_add_sched: RTL

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_add_sched.sv
// serial_add_sched: two requesters share one full-adder slice. WIDTH-bit
// sums are computed bit-serially, LSB first, over exactly WIDTH RUN cycles.
// The result is then held in DONE until the consumer takes it.
// Optional macro SERIAL_ADD_SCHED_RR_EN: round-robin arbitration on ties.
// Without it, requester 0 has fixed priority.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             gnt0, gnt1, accept, last_bit, s_bit, c_next;

`ifdef SERIAL_ADD_SCHED_RR_EN
  // ptr_q holds the id of the last granted requester; the other one wins a tie
  logic ptr_q;

  // Grant the requester not served last when both are valid
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt0 = ptr_q;
      gnt1 = !ptr_q;
    end
  end

  // Remember who was served; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr_q <= 1'b1;
    else if (accept) ptr_q <= gnt1;
  end
`else
  // Fixed priority: requester 0 always wins a tie
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid && !req0_valid;
`endif

  assign accept   = (state_q == IDLE) && (gnt0 || gnt1);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The shared full-adder slice works on the LSBs of the shifting operands
  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake readies; readies only ever come up in IDLE
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) state_d = RUN;
      end
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one bit per RUN cycle.
  // Sum bits enter at the MSB, so after WIDTH shifts they are aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      id_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q   <= gnt1 ? req1_a : req0_a;
          b_q   <= gnt1 ? req1_b : req0_b;
          id_q  <= gnt1;
          sum_q <= '0;
          c_q   <= 1'b0;
          cnt_q <= '0;
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          c_q   <= c_next;
          cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_sum   = sum_q;
  assign res_cout  = c_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
